miner_result_uart_tx: RTL and testbench
=======================================

# miner_result_uart_tx

Result-reporting transmitter for the bitcoin miner. It watches the miner's status and result outputs (`found`, `exhausted`, `nonce_out`, `hash_out`) and, on each completion event, captures the result. It then sends the captured result to the host as one fixed-length UART 8N1 frame. It is the outbound counterpart of the board-level job/control path that starts the miner, and it sits beside `bitcoin_miner` in the board top, driving a GPIO/UART TX pin.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200 baud). Legal minimum is 2.
- `clk`, input, 1: single system clock. All logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `found`, input, 1: miner found flag (level).
- `exhausted`, input, 1: miner search-exhausted flag (level).
- `nonce_out`, input, 32: miner result nonce.
- `hash_out`, input, 256: miner result hash.
- `uart_tx`, output, 1: serial line, idle high.
- `tx_busy`, output, 1: high while a frame is captured or being sent.
- `frame_done`, output, 1: one-cycle pulse after the last stop bit.
- `overrun`, output, 1: sticky flag. Set when an event is dropped because a frame is in flight.

## Operation
- **Event detection**
  - Registered copies `found_q` and `exhausted_q` reset to 0.
  - event = (found & ~found_q) | (exhausted & ~exhausted_q), evaluated every cycle.
  - Because the copies reset to 0, a flag already high at reset release produces an event on the first clock.
- **Capture (in IDLE only)**
  - On an event, latch `nonce_out`, `hash_out` and status = {6'b0, exhausted, found} as sampled in that cycle.
  - If both flags rise in the same cycle, status = 0x03 and a single frame is sent.
- **Frame format:** 39 bytes, each sent LSB first.
  - Byte 0: sync, 0xA5.
  - Byte 1: status.
  - Bytes 2–5: nonce, most-significant byte first.
  - Bytes 6–37: hash, most-significant byte first.
  - Byte 38: checksum, the XOR of bytes 1..37 (sync excluded).
- **Per-byte UART framing:** start bit 0, 8 data bits, 1 stop bit 1. There is no gap between bytes.
- **State machine: IDLE → START → DATA → STOP**
  - IDLE → START on an event (capture).
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA stays 8 × `CLKS_PER_BIT` cycles, using bit index 0..7.
  - DATA → STOP after bit 7.
  - STOP → START if byte index < 38, with the index incremented.
  - STOP → IDLE if byte index = 38.
- **Counters**
  - Baud counter: width ceil(log2(`CLKS_PER_BIT`)). It counts 0..`CLKS_PER_BIT`-1 and the bit advances at terminal count.
  - Byte index: 6 bits, 0..38. It never wraps past 38.
- **Checksum:** computed incrementally as each byte is loaded, or precomputed at capture. Either way, byte 38 on the wire must match.
- **Overrun**
  - An event detected while not in IDLE is dropped: latched data is unchanged and the current frame is unaffected.
  - `overrun` is set and stays set until reset.
- **Event on the IDLE-return cycle:** an event in the same cycle as STOP → IDLE is dropped and sets `overrun`. Capture happens only when the state is IDLE at the clock edge.

## Timing
- **Reset values:** `uart_tx`=1, `tx_busy`=0, `frame_done`=0, `overrun`=0, state IDLE, all counters 0. Reset takes effect immediately and asynchronously.
- **Reset mid-frame:** the line returns high immediately. The frame is abandoned and not resumed.
- **Start latency:** if the event edge is at cycle N, the start bit drives `uart_tx`=0 from cycle N+1. `tx_busy`=1 from cycle N+1.
- **Bit timing:** every bit is held exactly `CLKS_PER_BIT` cycles.
- **Frame length:** 390 × `CLKS_PER_BIT` cycles.
- **Frame end:** `frame_done` pulses high for one cycle, and `tx_busy` falls, in the cycle after the final stop bit's last cycle. A new event is accepted from that cycle onward.
- **Output quality:** `uart_tx` is driven from a flop, so it is glitch-free.
- **Input stability:** inputs are sampled only at capture. Later changes to `nonce_out` or `hash_out` do not affect the frame.

## Test plan
- **Reset idle:** `CLKS_PER_BIT`=4; hold reset, then release with all inputs 0 for 100 cycles. Required: `uart_tx`=1, `tx_busy`=0, `overrun`=0 throughout.
- **Found frame, all-zero result:** nonce=0, hash=0, then raise `found`.
  - 39 bytes decode as A5 01 00×36 01.
  - Start bit begins 1 cycle after the edge.
  - `frame_done` fires at 1560 cycles.
- **Exhausted frame:** nonce=0x00010000, hash=0, raise `exhausted`.
  - Bytes decode as A5 02 00 01 00 00 00×32 03.
  - `found` stays 0.
- **Simultaneous events:** nonce=0x7C2BAC1D, hash=0xFF..FF; raise `found` and `exhausted` in the same cycle.
  - Exactly one frame, with status 03.
  - Nonce bytes 7C 2B AC 1D, 32 × FF.
  - Checksum equals the reference-model XOR.
- **Overrun:** raise `found` mid-frame after a prior `exhausted` frame started.
  - The current frame is unchanged.
  - `overrun`=1 and stays set.
  - No second frame is sent.
  - Repeat with the event exactly on the STOP → IDLE cycle: same result.
- **Reset mid-frame and input stability:**
  - Assert `rst_n`=0 during byte 10. `uart_tx` goes to 1 asynchronously. After release, the line stays idle until a new edge.
  - Change `nonce_out` during a frame. The transmitted nonce is the captured value.

Source files
------------

// File: rtl/miner_result_uart_tx_if.sv
// Miner status/result bus as seen by the result-reporting UART transmitter.
interface miner_result_uart_tx_if;
    logic         found;
    logic         exhausted;
    logic [31:0]  nonce_out;
    logic [255:0] hash_out;

    modport master (output found, exhausted, nonce_out, hash_out);
    modport slave  (input  found, exhausted, nonce_out, hash_out);
endinterface

// File: rtl/miner_result_uart_tx.sv
// Captures each miner completion event and sends it to the host as one
// 39-byte UART 8N1 frame: A5, status, nonce[4], hash[32], XOR checksum.
module miner_result_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  rst_n,
    miner_result_uart_tx_if.slave miner,
    output logic                  uart_tx,
    output logic                  tx_busy,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_TC = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [5:0]      LAST_BYTE = 6'd38;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [5:0]          byte_q, byte_d;
    logic                found_q, exh_q;
    logic [7:0]          status_q, csum_q, csum_in, tx_byte;
    logic [31:0]         nonce_q;
    logic [255:0]        hash_q;
    logic                evt, baud_tc, capture, tx_d, done_d;

    assign evt     = (miner.found & ~found_q) | (miner.exhausted & ~exh_q);
    assign baud_tc = (baud_q == BAUD_TC);
    assign tx_busy = (state_q != S_IDLE);

    // Checksum is taken over the inputs at capture so the frame needs no running XOR.
    always_comb begin
        csum_in = {6'b0, miner.exhausted, miner.found};
        for (int k = 0; k < 4; k++)  csum_in = csum_in ^ miner.nonce_out[8*k +: 8];
        for (int k = 0; k < 32; k++) csum_in = csum_in ^ miner.hash_out[8*k +: 8];
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        capture = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (evt) begin
                    state_d = S_START;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    capture = 1'b1;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    baud_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = S_IDLE;
                        byte_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_START;
                        byte_d  = byte_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        int idx;
        idx     = int'(byte_d);
        tx_byte = 8'hA5;
        if (idx == 1)       tx_byte = status_q;
        else if (idx <= 5 && idx >= 2)  tx_byte = nonce_q[8*(5-idx) +: 8];
        else if (idx <= 37 && idx >= 6) tx_byte = hash_q[8*(37-idx) +: 8];
        else if (idx == 38) tx_byte = csum_q;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = tx_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    // Line level is registered from the next-state view so it changes only on clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            uart_tx    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            uart_tx    <= tx_d;
            frame_done <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found_q  <= 1'b0;
            exh_q    <= 1'b0;
            status_q <= '0;
            nonce_q  <= '0;
            hash_q   <= '0;
            csum_q   <= '0;
            overrun  <= 1'b0;
        end else begin
            found_q <= miner.found;
            exh_q   <= miner.exhausted;
            if (capture) begin
                status_q <= {6'b0, miner.exhausted, miner.found};
                nonce_q  <= miner.nonce_out;
                hash_q   <= miner.hash_out;
                csum_q   <= csum_in;
            end
            if (evt && state_q != S_IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_miner_result_uart_tx.sv
// Bench for miner_result_uart_tx: decodes the serial line and compares each
// frame with bytes built from the captured result.
module tb_miner_result_uart_tx;
    localparam int C         = 4;
    localparam int BYTE_CYC  = 10 * C;
    localparam int FRAME_CYC = 390 * C;

    logic clk = 1'b0;
    logic rst_n;
    logic uart_tx, tx_busy, frame_done, overrun;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] exp_bytes [39];
    logic [7:0] got_bytes [39];
    bit   aborted;

    miner_result_uart_tx_if mif ();

    miner_result_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .miner      (mif.slave),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] h;
        for (int k = 0; k < 8; k++) h[32*k +: 32] = $urandom();
        return h;
    endfunction

    function automatic void build_expected(input logic [7:0] st, input logic [31:0] n,
                                           input logic [255:0] h);
        logic [7:0] x;
        exp_bytes[0] = 8'hA5;
        exp_bytes[1] = st;
        for (int k = 0; k < 4; k++)  exp_bytes[2+k] = 8'((n >> (8*(3-k))) & 32'hFF);
        for (int k = 0; k < 32; k++) exp_bytes[6+k] = 8'(h >> (8*(31-k)));
        x = 8'h00;
        for (int k = 1; k <= 37; k++) x = x ^ exp_bytes[k];
        exp_bytes[38] = x;
    endfunction

    task automatic compare_frame(input string tag);
        for (int k = 0; k < 39; k++)
            chk($sformatf("%s_byte%0d", tag, k), got_bytes[k], exp_bytes[k]);
    endtask

    // Call at the negedge where the event was driven; each loop step is one DUT cycle.
    task automatic run_frame(input int inject_at, input int inject_kind, input int abort_at,
                             output bit was_aborted);
        int glitch = 0, framing = 0, busy_bad = 0, done_bad = 0;
        int off, p, ph, b;
        logic cur = 1'b1;
        logic [7:0] acc = 8'h00;
        was_aborted = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_async_tx", {63'b0, uart_tx}, 64'd1);
                chk("rst_async_busy", {63'b0, tx_busy}, 64'd0);
                was_aborted = 1'b1;
                return;
            end
            off = i % BYTE_CYC;
            p   = off / C;
            ph  = off % C;
            b   = i / BYTE_CYC;
            if (i == 0) chk("start_latency", {63'b0, uart_tx}, 64'd0);
            if (tx_busy !== 1'b1) busy_bad++;
            if (frame_done !== 1'b0) done_bad++;
            if (ph == 0) begin
                cur = uart_tx;
                case (p)
                    0:       if (cur !== 1'b0) framing++;
                    9: begin
                        if (cur !== 1'b1) framing++;
                        got_bytes[b] = acc;
                    end
                    default: acc[p-1] = cur;
                endcase
            end else if (uart_tx !== cur) begin
                glitch++;
            end
            if (i == inject_at) begin
                if (inject_kind == 1) mif.found = 1'b1;
                else if (inject_kind == 2) mif.nonce_out = $urandom();
            end
        end
        chk("bit_hold", glitch, 0);
        chk("framing", framing, 0);
        chk("busy_in_frame", busy_bad, 0);
        chk("done_in_frame", done_bad, 0);
        @(negedge clk);
        chk("frame_done_end", {63'b0, frame_done}, 64'd1);
        chk("busy_end", {63'b0, tx_busy}, 64'd0);
        chk("line_end", {63'b0, uart_tx}, 64'd1);
        @(negedge clk);
        chk("done_pulse", {63'b0, frame_done}, 64'd0);
    endtask

    task automatic idle_window(input int n, input string tag);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        mif.found     = 1'b0;
        mif.exhausted = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {63'b0, uart_tx}, 64'd1);
        chk("rst_busy", {63'b0, tx_busy}, 64'd0);
        chk("rst_done", {63'b0, frame_done}, 64'd0);
        chk("rst_ovr", {63'b0, overrun}, 64'd0);
        rst_n = 1'b1;
    endtask

    task automatic start_event(input logic f, input logic e, input logic [31:0] n,
                               input logic [255:0] h);
        @(negedge clk);
        mif.nonce_out = n;
        mif.hash_out  = h;
        mif.found     = f;
        mif.exhausted = e;
        build_expected({6'b0, e, f}, n, h);
    endtask

    task automatic lower_flags();
        @(negedge clk);
        mif.found     = 1'b0;
        mif.exhausted = 1'b0;
    endtask

    initial begin
        logic [31:0]  n;
        logic [255:0] h;
        int           sel;
        rst_n         = 1'b0;
        mif.found     = 1'b0;
        mif.exhausted = 1'b0;
        mif.nonce_out = '0;
        mif.hash_out  = '0;

        do_reset();
        idle_window(100, "reset_idle");
        chk("reset_idle_ovr", {63'b0, overrun}, 64'd0);

        start_event(1'b1, 1'b0, 32'h0, 256'h0);
        run_frame(-1, 0, -1, aborted);
        compare_frame("found0");
        chk("found0_csum", got_bytes[38], 64'h01);
        chk("found0_ovr", {63'b0, overrun}, 64'd0);
        lower_flags();

        start_event(1'b0, 1'b1, 32'h0001_0000, 256'h0);
        run_frame(-1, 0, -1, aborted);
        compare_frame("exh");
        chk("exh_status", got_bytes[1], 64'h02);
        chk("exh_nonce1", got_bytes[3], 64'h01);
        chk("exh_csum", got_bytes[38], 64'h03);
        lower_flags();

        start_event(1'b1, 1'b1, 32'h7C2B_AC1D, {256{1'b1}});
        run_frame(-1, 0, -1, aborted);
        compare_frame("both");
        chk("both_status", got_bytes[1], 64'h03);
        idle_window(50, "both_single_frame");
        chk("both_ovr", {63'b0, overrun}, 64'd0);
        lower_flags();

        start_event(1'b1, 1'b0, $urandom(), rand256());
        run_frame(50 * C, 2, -1, aborted);
        compare_frame("stable");
        lower_flags();

        start_event(1'b0, 1'b1, $urandom(), rand256());
        run_frame(100 * C, 1, -1, aborted);
        compare_frame("ovr_mid");
        chk("ovr_mid_flag", {63'b0, overrun}, 64'd1);
        idle_window(60, "ovr_mid_no_second");
        chk("ovr_sticky", {63'b0, overrun}, 64'd1);

        do_reset();
        start_event(1'b0, 1'b1, $urandom(), rand256());
        run_frame(FRAME_CYC - 1, 1, -1, aborted);
        compare_frame("ovr_last");
        chk("ovr_last_flag", {63'b0, overrun}, 64'd1);
        idle_window(60, "ovr_last_no_second");
        lower_flags();

        do_reset();
        start_event(1'b1, 1'b0, $urandom(), rand256());
        run_frame(-1, 0, 10 * BYTE_CYC, aborted);
        mif.found = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hold_tx", {63'b0, uart_tx}, 64'd1);
        rst_n = 1'b1;
        idle_window(50, "post_rst_idle");
        chk("post_rst_ovr", {63'b0, overrun}, 64'd0);

        for (int t = 0; t < 6; t++) begin
            sel = $urandom_range(1, 3);
            n   = $urandom();
            h   = rand256();
            start_event(sel[0], sel[1], n, h);
            run_frame(-1, 0, -1, aborted);
            compare_frame($sformatf("rand%0d", t));
            lower_flags();
        end
        chk("final_ovr", {63'b0, overrun}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
